id_pipe: RTL
============

# id_pipe

Parametrised instruction-decode pipeline stage for the cqu_mips five-stage core, sitting between the IF/ID boundary and EX. Decodes the MIPS-I integer subset into a full control bundle and sign/zero-extended immediate. Resolves rs/rt operands through an N-source forwarding network and detects load-use hazards. Registers everything behind a valid/ready handshake with stall and flush, so the stage costs exactly one cycle.

## Interface
- `XLEN`, 32: data/PC width.
- `FWD_SRCS`, 2: number of forwarding sources, 1..4; index 0 has highest priority.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: IF presents an instruction.
- `in_ready` out 1: ID accepts this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: PC of `in_inst`.
- `rf_rs_addr`, `rf_rt_addr` out 5: combinational `in_inst[25:21]`, `in_inst[20:16]`.
- `rf_rs_data`, `rf_rt_data` in XLEN: register-file read data, same cycle.
- `fwd_valid` in FWD_SRCS: source k is writing.
- `fwd_addr` in 5*FWD_SRCS: destination of source k.
- `fwd_data` in XLEN*FWD_SRCS: result of source k.
- `ex_mem_read` in 1: instruction currently in EX is a load.
- `ex_rt` in 5: load destination in EX.
- `flush` in 1: discard ID contents and incoming instruction.
- `out_valid` out 1, `out_ready` in 1: EX handshake.
- `out_inst` out 32, `out_pc` out XLEN, `out_pc_plus_4` out XLEN.
- `out_rs`, `out_rt`, `out_wb_addr` out 5.
- `out_rs_data`, `out_rt_data` out XLEN: resolved operands.
- `out_ext_imm` out XLEN: extended immediate.
- `out_alu_op` out 4.
- `out_alu_src`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_branch`, `out_branch_ne`, `out_jump`, `out_link`, `out_illegal` out 1.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9, LUI 10.
- R-type (opcode 0) funct decode:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR; 0x2A → SLT.
  - 0x00/0x02/0x03 → SLL/SRL/SRA.
  - All R-type: reg_write=1, `wb_addr`=rd.
- I-type: `wb_addr`=rt, alu_src=1.
  - 0x08/0x09 → ADD, sign-extend; 0x0A → SLT, sign-extend.
  - 0x0C/0x0D/0x0E → AND/OR/XOR, zero-extend.
  - 0x0F → LUI, imm placed in `[31:16]`.
- Memory: 0x23 LW → ADD, mem_read, mem_to_reg, reg_write. 0x2B SW → ADD, mem_write, reg_write=0.
- Branches: 0x04 BEQ / 0x05 BNE → branch=1, SUB, alu_src=0; BNE also sets branch_ne.
- Jumps: 0x02 J → jump. 0x03 JAL → jump, link, reg_write, `wb_addr`=31.
- Any other opcode/funct: illegal=1, all write/mem/branch/jump controls 0.
- `wb_addr`=0 forces reg_write=0.
- Forwarding, per operand:
  - Addr 0 → 0.
  - Else the lowest k with `fwd_valid[k]` and `fwd_addr[k]`==addr supplies the data.
  - Else register-file data.
- Load-use hazard when in_valid & ex_mem_read & ex_rt≠0 & (ex_rt==rs | (ex_rt==rt & instruction reads rt)).
  - "Reads rt" means R-type, SW, BEQ or BNE.
- Advance condition: `adv` = out_ready | !out_valid.
- `in_ready` = adv & !hazard & !flush.
- On `adv` & hazard & !flush: register a bubble (out_valid=0), hold IF.
- On flush: out_valid←0 next edge; in_ready=0; input discarded. Flush overrides hazard and handshake.
- When !adv: all outputs hold.

## Timing
- Latency 1: instruction accepted at edge n appears on outputs after edge n.
- Decode, forwarding and hazard logic are combinational on the input side; all `out_*` are registered.
- Reset (rstn=0 at an edge): every `out_*` ←0, including out_valid, `out_alu_op` and `out_illegal`. in_ready=0 while rstn=0.
- Reset mid-transfer drops the held instruction; no replay.
- out_valid & !out_ready: payload stable until accepted (AXI-style; no combinational out_ready→out_* path).
- Simultaneous flush and out_ready: the current output is consumed, then out_valid=0.

## Structure
- Shared package/header `defines.vh`:
  - Opcode and funct constants (`EXE_*`).
  - ALU code constants `ALU_ADD`..`ALU_LUI`.
  - Link register index 31.
- Sub-module `id_fwd_mux` (parameter FWD_SRCS, XLEN), instantiated twice, for rs and rt.
- Decode lives in one combinational block; the output register is in the top module.

## Test plan
- Reset: hold rstn=0 for 3 cycles with in_valid=1 → all outputs 0, in_ready=0. After release, the first instruction appears one cycle later.
- Decode sweep:
  - ADDI r2,r1,-1 (0x2022FFFF) → alu_op 0, ext_imm 0xFFFFFFFF, wb_addr 2.
  - ORI r2,r1,0xFFFF → ext_imm 0x0000FFFF.
  - JAL → wb_addr 31, link=1.
  - Opcode 0x3F → illegal=1, reg_write=0.
- Forwarding: rs=5, fwd[0]=(5, 0xAAAA), fwd[1]=(5, 0xBBBB) → out_rs_data 0xAAAA. With fwd_valid[0]=0 → 0xBBBB. rs=0 with a matching fwd → 0.
- Load-use: EX holds LW to r3, ID presents ADD r4,r3,r1 → one bubble, in_ready=0 for 1 cycle, then the ADD issues.
- Backpressure: out_ready=0 for 4 cycles with a valid output → payload unchanged, in_ready=0, no instruction lost or duplicated.
- Flush: flush during a stall or with in_valid=1 → next cycle out_valid=0 and the input is dropped. Flush together with a hazard → flush wins.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared constants and types for the ID stage: MIPS-I opcode/funct encodings,
// ALU operation codes and the registered control bundle.
package id_pipe_pkg;

    localparam logic [5:0] EXE_SPECIAL = 6'h00;
    localparam logic [5:0] EXE_J       = 6'h02;
    localparam logic [5:0] EXE_JAL     = 6'h03;
    localparam logic [5:0] EXE_BEQ     = 6'h04;
    localparam logic [5:0] EXE_BNE     = 6'h05;
    localparam logic [5:0] EXE_ADDI    = 6'h08;
    localparam logic [5:0] EXE_ADDIU   = 6'h09;
    localparam logic [5:0] EXE_SLTI    = 6'h0A;
    localparam logic [5:0] EXE_ANDI    = 6'h0C;
    localparam logic [5:0] EXE_ORI     = 6'h0D;
    localparam logic [5:0] EXE_XORI    = 6'h0E;
    localparam logic [5:0] EXE_LUI     = 6'h0F;
    localparam logic [5:0] EXE_LW      = 6'h23;
    localparam logic [5:0] EXE_SW      = 6'h2B;

    // funct field values for opcode EXE_SPECIAL
    localparam logic [5:0] EXE_SLL  = 6'h00;
    localparam logic [5:0] EXE_SRL  = 6'h02;
    localparam logic [5:0] EXE_SRA  = 6'h03;
    localparam logic [5:0] EXE_ADD  = 6'h20;
    localparam logic [5:0] EXE_ADDU = 6'h21;
    localparam logic [5:0] EXE_SUB  = 6'h22;
    localparam logic [5:0] EXE_SUBU = 6'h23;
    localparam logic [5:0] EXE_AND  = 6'h24;
    localparam logic [5:0] EXE_OR   = 6'h25;
    localparam logic [5:0] EXE_XOR  = 6'h26;
    localparam logic [5:0] EXE_NOR  = 6'h27;
    localparam logic [5:0] EXE_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] wb_addr;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_pipe_fwd_mux.sv
// Operand forwarding mux: register 0 reads as zero, otherwise the lowest-index
// matching forwarding source wins over the register-file value.
module id_fwd_mux #(
    parameter int FWD_SRCS = 2,
    parameter int XLEN     = 32
) (
    input  logic [4:0]               addr,
    input  logic [XLEN-1:0]          rf_data,
    input  logic [FWD_SRCS-1:0]      fwd_valid,
    input  logic [5*FWD_SRCS-1:0]    fwd_addr,
    input  logic [XLEN*FWD_SRCS-1:0] fwd_data,
    output logic [XLEN-1:0]          data
);

    logic [FWD_SRCS-1:0] match;

    for (genvar gi = 0; gi < FWD_SRCS; gi++) begin : g_match
        assign match[gi] = fwd_valid[gi] && (fwd_addr[gi*5 +: 5] == addr);
    end

    // Scan from the lowest-priority source down so index 0 is applied last.
    always_comb begin
        data = rf_data;
        for (int k = FWD_SRCS - 1; k >= 0; k--) begin
            if (match[k]) begin
                data = fwd_data[k*XLEN +: XLEN];
            end
        end
        if (addr == 5'd0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// Instruction-decode stage: combinational decode, forwarding and load-use
// detection feeding a single registered valid/ready output slot.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic [4:0]               rf_rs_addr,
    output logic [4:0]               rf_rt_addr,
    input  logic [XLEN-1:0]          rf_rs_data,
    input  logic [XLEN-1:0]          rf_rt_data,
    input  logic [FWD_SRCS-1:0]      fwd_valid,
    input  logic [5*FWD_SRCS-1:0]    fwd_addr,
    input  logic [XLEN*FWD_SRCS-1:0] fwd_data,
    input  logic                     ex_mem_read,
    input  logic [4:0]               ex_rt,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pc_plus_4,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_wb_addr,
    output logic [XLEN-1:0]          out_rs_data,
    output logic [XLEN-1:0]          out_rt_data,
    output logic [XLEN-1:0]          out_ext_imm,
    output logic [3:0]               out_alu_op,
    output logic                     out_alu_src,
    output logic                     out_reg_write,
    output logic                     out_mem_read,
    output logic                     out_mem_write,
    output logic                     out_mem_to_reg,
    output logic                     out_branch,
    output logic                     out_branch_ne,
    output logic                     out_jump,
    output logic                     out_link,
    output logic                     out_illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign imm    = in_inst[15:0];
    assign funct  = in_inst[5:0];

    assign rf_rs_addr = rs;
    assign rf_rt_addr = rt;

    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] imm_d, imm_q;
    logic            reads_rt;

    always_comb begin
        ctrl_d = '0;
        imm_d  = XLEN'($signed(imm));
        case (opcode)
            EXE_SPECIAL: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wb_addr   = rd;
                case (funct)
                    EXE_ADD, EXE_ADDU: ctrl_d.alu_op = ALU_ADD;
                    EXE_SUB, EXE_SUBU: ctrl_d.alu_op = ALU_SUB;
                    EXE_AND:           ctrl_d.alu_op = ALU_AND;
                    EXE_OR:            ctrl_d.alu_op = ALU_OR;
                    EXE_XOR:           ctrl_d.alu_op = ALU_XOR;
                    EXE_NOR:           ctrl_d.alu_op = ALU_NOR;
                    EXE_SLT:           ctrl_d.alu_op = ALU_SLT;
                    EXE_SLL:           ctrl_d.alu_op = ALU_SLL;
                    EXE_SRL:           ctrl_d.alu_op = ALU_SRL;
                    EXE_SRA:           ctrl_d.alu_op = ALU_SRA;
                    default:           ctrl_d.illegal = 1'b1;
                endcase
            end
            EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wb_addr   = rt;
                case (opcode)
                    EXE_SLTI: ctrl_d.alu_op = ALU_SLT;
                    EXE_ANDI: begin ctrl_d.alu_op = ALU_AND; imm_d = XLEN'(imm); end
                    EXE_ORI:  begin ctrl_d.alu_op = ALU_OR;  imm_d = XLEN'(imm); end
                    EXE_XORI: begin ctrl_d.alu_op = ALU_XOR; imm_d = XLEN'(imm); end
                    EXE_LUI:  begin ctrl_d.alu_op = ALU_LUI; imm_d = XLEN'({imm, 16'h0000}); end
                    default:  ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            EXE_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.wb_addr    = rt;
            end
            EXE_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.wb_addr   = rt;
            end
            EXE_BEQ, EXE_BNE: begin
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.branch    = 1'b1;
                ctrl_d.branch_ne = (opcode == EXE_BNE);
                ctrl_d.wb_addr   = rt;
            end
            EXE_J: ctrl_d.jump = 1'b1;
            EXE_JAL: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.link      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wb_addr   = LINK_REG;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
        // An unknown encoding must not have any architectural side effect.
        if (ctrl_d.illegal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
        end
        if (ctrl_d.wb_addr == 5'd0) begin
            ctrl_d.reg_write = 1'b0;
        end
    end

    assign reads_rt = (opcode == EXE_SPECIAL) || (opcode == EXE_SW) ||
                      (opcode == EXE_BEQ) || (opcode == EXE_BNE);

    logic [XLEN-1:0] rs_data_d, rt_data_d;

    id_fwd_mux #(.FWD_SRCS(FWD_SRCS), .XLEN(XLEN)) u_fwd_rs (
        .addr      (rs),
        .rf_data   (rf_rs_data),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .data      (rs_data_d)
    );

    id_fwd_mux #(.FWD_SRCS(FWD_SRCS), .XLEN(XLEN)) u_fwd_rt (
        .addr      (rt),
        .rf_data   (rf_rt_data),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .data      (rt_data_d)
    );

    logic valid_q, valid_d;
    logic hazard, adv, load;

    assign hazard = in_valid && ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));
    assign adv      = out_ready || !valid_q;
    assign in_ready = rstn && adv && !hazard && !flush;
    assign load     = in_ready && in_valid;

    // Flush wins over everything; a stalled slot keeps its contents.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = in_valid && !hazard;
        end
    end

    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q, pc4_q, rs_data_q, rt_data_q;
    logic [4:0]      rs_q, rt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            inst_q    <= '0;
            pc_q      <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                inst_q    <= in_inst;
                pc_q      <= in_pc;
                pc4_q     <= in_pc + XLEN'(4);
                rs_q      <= rs;
                rt_q      <= rt;
                rs_data_q <= rs_data_d;
                rt_data_q <= rt_data_d;
                imm_q     <= imm_d;
                ctrl_q    <= ctrl_d;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_inst       = inst_q;
    assign out_pc         = pc_q;
    assign out_pc_plus_4  = pc4_q;
    assign out_rs         = rs_q;
    assign out_rt         = rt_q;
    assign out_wb_addr    = ctrl_q.wb_addr;
    assign out_rs_data    = rs_data_q;
    assign out_rt_data    = rt_data_q;
    assign out_ext_imm    = imm_q;
    assign out_alu_op     = ctrl_q.alu_op;
    assign out_alu_src    = ctrl_q.alu_src;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_branch     = ctrl_q.branch;
    assign out_branch_ne  = ctrl_q.branch_ne;
    assign out_jump       = ctrl_q.jump;
    assign out_link       = ctrl_q.link;
    assign out_illegal    = ctrl_q.illegal;

endmodule
